// File: rtl/wmc_pkg.sv
// rtl/wmc_pkg.sv - shared dispense-arbiter state/size encodings and default fill durations
package wmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    SZ_REG   = 1'b0,
    SZ_LARGE = 1'b1
  } size_e;

  // Also used by the washing-machine controller so both sides agree on fill lengths.
  localparam int DEF_REG_FILL   = 8;
  localparam int DEF_LARGE_FILL = 12;

endpackage

// File: rtl/wmc_rr_picker.sv
// rtl/wmc_rr_picker.sv - combinational one-hot picker, first requester at or above ptr with wrap
module wmc_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [PW-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/wmc_dispense_arbiter.sv
// rtl/wmc_dispense_arbiter.sv - shared water/soap inlet arbiter for N_MACH washing-machine controllers
// WMC_DISP_ARB_RR_EN selects round-robin; undefined gives fixed lowest-index priority.
module wmc_dispense_arbiter
  import wmc_pkg::*;
#(
  parameter int N_MACH     = 4,
  parameter int REG_FILL   = DEF_REG_FILL,
  parameter int LARGE_FILL = DEF_LARGE_FILL,
  parameter int CNT_W      = 8
) (
  input  logic              CLOCK,
  input  logic              nRESET,
  input  logic              TICK,
  input  logic [N_MACH-1:0] REQ_REG,
  input  logic [N_MACH-1:0] REQ_LARGE,
  output logic [N_MACH-1:0] GRANT,
  output logic [N_MACH-1:0] DONE,
  output logic              VALVE_REG,
  output logic              VALVE_LARGE,
  output logic              BUSY
);

  localparam int PW = $clog2(N_MACH);

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_MACH-1:0] grant_q, grant_d;
  logic [N_MACH-1:0] done_q, done_d;
  logic              vreg_q, vreg_d;
  logic              vlarge_q, vlarge_d;
  logic              busy_q, busy_d;

  logic [N_MACH-1:0] req_any;
  logic [N_MACH-1:0] pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [PW-1:0]     ptr;

  assign req_any = REQ_REG | REQ_LARGE;

`ifdef WMC_DISP_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_nxt;
  assign idx_nxt = (idx_q == PW'(N_MACH - 1)) ? '0 : idx_q + PW'(1);
  assign ptr     = ptr_q;
`else
  assign ptr = '0;
`endif

  wmc_rr_picker #(.N(N_MACH), .PW(PW)) u_picker (
    .req (req_any),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    done_d   = '0;
    vreg_d   = vreg_q;
    vlarge_d = vlarge_q;
    busy_d   = busy_q;
`ifdef WMC_DISP_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_FILL;
          idx_d    = pick_idx;
          grant_d  = pick_gnt;
          busy_d   = 1'b1;
          size_d   = REQ_LARGE[pick_idx] ? SZ_LARGE : SZ_REG;
          cnt_d    = REQ_LARGE[pick_idx] ? CNT_W'(LARGE_FILL) : CNT_W'(REG_FILL);
          vreg_d   = !REQ_LARGE[pick_idx];
          vlarge_d = REQ_LARGE[pick_idx];
        end
      end
      ST_FILL: begin
        // Abort is checked first so it beats a coincident final tick.
        if (!req_any[idx_q]) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          vreg_d   = 1'b0;
          vlarge_d = 1'b0;
          busy_d   = 1'b0;
`ifdef WMC_DISP_ARB_RR_EN
          ptr_d    = idx_nxt;
`endif
        end else begin
          vreg_d   = (size_q == SZ_REG);
          vlarge_d = (size_q == SZ_LARGE);
          if (TICK) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d  = ST_DONE;
              vreg_d   = 1'b0;
              vlarge_d = 1'b0;
              done_d   = grant_q;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
`ifdef WMC_DISP_ARB_RR_EN
        ptr_d   = idx_nxt;
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        vreg_d   = 1'b0;
        vlarge_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(negedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= ST_IDLE;
      size_q   <= SZ_REG;
      idx_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      vreg_q   <= 1'b0;
      vlarge_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef WMC_DISP_ARB_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      vreg_q   <= vreg_d;
      vlarge_q <= vlarge_d;
      busy_q   <= busy_d;
`ifdef WMC_DISP_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign GRANT       = grant_q;
  assign DONE        = done_q;
  assign VALVE_REG   = vreg_q;
  assign VALVE_LARGE = vlarge_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_wmc_dispense_arbiter.sv
// tb/tb_wmc_dispense_arbiter.sv - directed bench for wmc_dispense_arbiter (N_MACH=4, REG_FILL=3, LARGE_FILL=5)
module tb_wmc_dispense_arbiter;

  logic       CLOCK;
  logic       nRESET;
  logic       TICK;
  logic [3:0] REQ_REG;
  logic [3:0] REQ_LARGE;
  logic [3:0] GRANT;
  logic [3:0] DONE;
  logic       VALVE_REG;
  logic       VALVE_LARGE;
  logic       BUSY;

  int vectors;
  int miscompares;

  wmc_dispense_arbiter #(
    .N_MACH     (4),
    .REG_FILL   (3),
    .LARGE_FILL (5),
    .CNT_W      (8)
  ) dut (
    .CLOCK       (CLOCK),
    .nRESET      (nRESET),
    .TICK        (TICK),
    .REQ_REG     (REQ_REG),
    .REQ_LARGE   (REQ_LARGE),
    .GRANT       (GRANT),
    .DONE        (DONE),
    .VALVE_REG   (VALVE_REG),
    .VALVE_LARGE (VALVE_LARGE),
    .BUSY        (BUSY)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  function automatic logic [10:0] o(input logic [3:0] g, input logic [3:0] d,
                                    input logic vr, input logic vl, input logic b);
    return {g, d, vr, vl, b};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {GRANT, DONE, VALVE_REG, VALVE_LARGE, BUSY};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%03h expected=%03h (grant,done,vreg,vlarge,busy)", tag, obs, exp);
    end
  endtask

  // One active (falling) edge with TICK=t; returns at the next rising edge + 1.
  task automatic e(input logic t);
    TICK = t;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic grp(input int n);
    for (int i = 0; i < n; i++) begin
      e(0); e(0); e(0); e(1);
    end
  endtask

  initial begin
    logic [3:0] g;
    int         w;
    vectors     = 0;
    miscompares = 0;
    nRESET      = 1'b0;
    TICK        = 1'b0;
    REQ_REG     = '0;
    REQ_LARGE   = '0;
    @(posedge CLOCK);
    #1;
    e(0); e(0);
    chk("reset", o(4'b0000, 4'b0000, 0, 0, 0));
    nRESET = 1'b1;
    e(0);
    chk("idle_after_reset", o(4'b0000, 4'b0000, 0, 0, 0));

    // Single regular fill, machine 0
    REQ_REG = 4'b0001;
    e(0);
    chk("reg_grant", o(4'b0001, 4'b0000, 1, 0, 1));
    grp(2);
    e(0); e(0); e(0);
    chk("reg_before_last_tick", o(4'b0001, 4'b0000, 1, 0, 1));
    e(1);
    chk("reg_done", o(4'b0001, 4'b0001, 0, 0, 1));
    REQ_REG = 4'b0000;
    e(0);
    chk("reg_idle", o(4'b0000, 4'b0000, 0, 0, 0));
    e(0);
    chk("reg_idle2", o(4'b0000, 4'b0000, 0, 0, 0));

    // Abort: machine 1 drops after one tick, machine 2 takes over
    REQ_REG = 4'b0110;
    e(0);
    chk("abort_grant1", o(4'b0010, 4'b0000, 1, 0, 1));
    grp(1);
    chk("abort_filling", o(4'b0010, 4'b0000, 1, 0, 1));
    REQ_REG = 4'b0100;
    e(0);
    chk("abort_no_done", o(4'b0000, 4'b0000, 0, 0, 0));
    e(0);
    chk("abort_next_grant2", o(4'b0100, 4'b0000, 1, 0, 1));

    // Abort coincident with the final tick: abort wins
    grp(2);
    e(0); e(0); e(0);
    chk("abort_tick_filling", o(4'b0100, 4'b0000, 1, 0, 1));
    REQ_REG = 4'b0000;
    e(1);
    chk("abort_tick_no_done", o(4'b0000, 4'b0000, 0, 0, 0));
    e(0);
    chk("abort_tick_idle", o(4'b0000, 4'b0000, 0, 0, 0));

    // Large precedence on machine 2
    REQ_REG   = 4'b0100;
    REQ_LARGE = 4'b0100;
    e(0);
    chk("large_grant", o(4'b0100, 4'b0000, 0, 1, 1));
    grp(4);
    e(0); e(0); e(0);
    chk("large_before_last_tick", o(4'b0100, 4'b0000, 0, 1, 1));
    e(1);
    chk("large_done", o(4'b0100, 4'b0100, 0, 0, 1));
    REQ_REG   = 4'b0000;
    REQ_LARGE = 4'b0000;
    e(0);
    chk("large_idle", o(4'b0000, 4'b0000, 0, 0, 0));

    // Tick every cycle, including the IDLE->FILL edge
    REQ_REG = 4'b0010;
    e(1);
    chk("edge_tick_v1", o(4'b0010, 4'b0000, 1, 0, 1));
    e(1);
    chk("edge_tick_v2", o(4'b0010, 4'b0000, 1, 0, 1));
    e(1);
    chk("edge_tick_v3", o(4'b0010, 4'b0000, 1, 0, 1));
    e(1);
    chk("edge_tick_done", o(4'b0010, 4'b0010, 0, 0, 1));
    REQ_REG = 4'b0000;
    e(1);
    chk("edge_tick_idle", o(4'b0000, 4'b0000, 0, 0, 0));

    // Reset mid large fill: outputs clear with no clock edge
    REQ_LARGE = 4'b1000;
    e(0);
    chk("rst_mid_grant", o(4'b1000, 4'b0000, 0, 1, 1));
    e(0); e(0);
    #2;
    nRESET = 1'b0;
    #1;
    chk("rst_mid_async", o(4'b0000, 4'b0000, 0, 0, 0));
    REQ_LARGE = 4'b0000;
    e(0);
    nRESET = 1'b1;
    e(0);
    chk("rst_mid_idle", o(4'b0000, 4'b0000, 0, 0, 0));

    // Fairness: all four request, each drops after DONE and re-raises
    REQ_REG = 4'b1111;
    for (int r = 0; r < 5; r++) begin
`ifdef WMC_DISP_ARB_RR_EN
      w = r % 4;
`else
      w = 0;
`endif
      g = 4'b0001 << w;
      e(0);
      chk($sformatf("fair_grant_r%0d", r), o(g, 4'b0000, 1, 0, 1));
      grp(3);
      chk($sformatf("fair_done_r%0d", r), o(g, g, 0, 0, 1));
      REQ_REG = 4'b1111 & ~g;
      e(0);
      chk($sformatf("fair_idle_r%0d", r), o(4'b0000, 4'b0000, 0, 0, 0));
      REQ_REG = 4'b1111;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
